isqrt_seq: RTL and testbench

Sequential integer square root, the inverse of the squarer. Takes a 2*BITWIDTH-bit operand and returns floor(sqrt(x)) plus remainder x - root^2, one root bit per cycle (digit-by-digit, restoring). Used by trial-factoring control to bound the candidate search at sqrt(N). Also checks squarer results by round-trip.

---
 rtl/isqrt_seq_pkg.sv | 9 +
 rtl/isqrt_step.sv | 20 ++
 rtl/isqrt_seq.sv | 88 ++++++++
 tb/tb_isqrt_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/isqrt_seq_pkg.sv
// isqrt_seq_pkg: shared FSM state encoding and default root width for the sequential integer square root
package isqrt_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DEF_BITWIDTH = 32;
endpackage

// File: rtl/isqrt_step.sv
// isqrt_step: one restoring digit-by-digit square root iteration, bringing in one operand bit pair
module isqrt_step #(
    parameter int BITWIDTH = 32
) (
    input  logic [BITWIDTH:0]   rem,
    input  logic [BITWIDTH-1:0] root,
    input  logic [1:0]          pair,
    output logic [BITWIDTH:0]   rem_o,
    output logic [BITWIDTH-1:0] root_o
);
    localparam int REMW = BITWIDTH + 1;
    logic [BITWIDTH+2:0] r;
    logic [BITWIDTH+2:0] t;
    logic                ge;
    assign r      = {rem, pair};
    assign t      = {1'b0, root, 2'b01};
    assign ge     = r >= t;
    assign rem_o  = ge ? REMW'(r - t) : REMW'(r);
    assign root_o = (root << 1) | BITWIDTH'(ge);
endmodule

// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential floor(sqrt(x)) with remainder, one root bit per cycle; define ISQRT_EARLY_EXIT_EN to skip leading zero bit pairs
module isqrt_seq
    import isqrt_seq_pkg::*;
#(
    parameter int BITWIDTH = DEF_BITWIDTH
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*BITWIDTH-1:0] x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BITWIDTH-1:0]   root,
    output logic [BITWIDTH:0]     rem
);
    localparam int OPW  = 2 * BITWIDTH;
    localparam int REMW = BITWIDTH + 1;
    localparam int CNTW = $clog2(BITWIDTH + 1);
    state_t              state_q, state_d;
    logic [OPW-1:0]      x_q, x_d;
    logic [REMW-1:0]     rem_q, rem_d, step_rem;
    logic [BITWIDTH-1:0] root_q, root_d, step_root;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [OPW-1:0]      x_load;
    logic [CNTW-1:0]     cnt_load;
    isqrt_step #(.BITWIDTH(BITWIDTH)) u_step (
        .rem   (rem_q),
        .root  (root_q),
        .pair  (x_q[OPW-1 -: 2]),
        .rem_o (step_rem),
        .root_o(step_root)
    );
`ifdef ISQRT_EARLY_EXIT_EN
    logic [CNTW-1:0] z;
    always_comb begin
        z = CNTW'(BITWIDTH);
        for (int i = 0; i < BITWIDTH; i++)
            if (x[2*i +: 2] != 2'b00) z = CNTW'(BITWIDTH - 1 - i);
        x_load   = x << {z, 1'b0};
        cnt_load = (z == CNTW'(BITWIDTH)) ? CNTW'(1) : CNTW'(BITWIDTH) - z;
    end
`else
    assign x_load   = x;
    assign cnt_load = CNTW'(BITWIDTH);
`endif
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && in_valid) begin
            state_d = CALC;
            x_d     = x_load;
            rem_d   = '0;
            root_d  = '0;
            cnt_d   = cnt_load;
        end else if (state_q == CALC) begin
            x_d     = x_q << 2;
            rem_d   = step_rem;
            root_d  = step_root;
            cnt_d   = cnt_q - CNTW'(1);
            state_d = (cnt_q == CNTW'(1)) ? DONE : CALC;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign root      = root_q;
    assign rem       = rem_q;
endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: vector table, hand-written corner sequences and random operands against an arithmetic square root model
module tb_isqrt_seq;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] x = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] root;
    logic [32:0] rem;
    int          total = 0;
    int          passed = 0;
    isqrt_seq #(.BITWIDTH(32)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .root     (root),
        .rem      (rem)
    );
    always #5 sys_clk = ~sys_clk;
    typedef struct {
        logic [63:0] x;
        logic [31:0] r;
        logic [32:0] m;
    } vec_t;
    vec_t vecs[9];
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    function automatic logic [31:0] model_root(input logic [63:0] v);
        logic [127:0] lo = 0, hi = 128'hFFFF_FFFF, mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= {64'd0, v}) lo = mid;
            else hi = mid - 1;
        end
        return lo[31:0];
    endfunction
    function automatic int exp_lat(input logic [63:0] v);
`ifdef ISQRT_EARLY_EXIT_EN
        int nb = 0;
        while (nb < 64 && (v >> nb) != 0) nb++;
        return ((nb + 1) / 2 < 1) ? 1 : (nb + 1) / 2;
`else
        return (v == v) ? 32 : 32;
`endif
    endfunction
    task automatic start(input logic [63:0] v);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge sys_clk); @(negedge sys_clk); n++;
        end
        if (n == 100) chk("in_ready_wait", 0, 1);
        in_valid = 1'b1;
        x = v;
        @(posedge sys_clk); @(negedge sys_clk);
        in_valid = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge sys_clk); lat++; @(negedge sys_clk);
        end
        if (lat == 200) chk("out_valid_wait", 0, 1);
    endtask
    task automatic consume;
        out_ready = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        out_ready = 1'b0;
    endtask
    task automatic run_check(input string name, input logic [63:0] v);
        int lat;
        logic [31:0] er;
        logic [127:0] r2;
        er = model_root(v);
        start(v);
        wait_done(lat);
        chk({name, "_root"}, root, er);
        chk({name, "_rem"}, rem, v - {32'd0, er} * {32'd0, er});
        chk({name, "_lat"}, lat, exp_lat(v));
        r2 = {96'd0, root} * {96'd0, root} + {95'd0, rem};
        chk({name, "_roundtrip"}, r2, {64'd0, v});
        chk({name, "_rem_le_2root"}, {95'd0, rem} <= {95'd0, root, 1'b0}, 1);
        consume;
    endtask
    initial begin
        int lat;
        logic [31:0] r0;
        logic [32:0] m0;
        vecs[0] = '{64'd99, 32'd9, 33'd18};
        vecs[1] = '{64'd0, 32'd0, 33'd0};
        vecs[2] = '{64'd1, 32'd1, 33'd0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
        vecs[4] = '{64'd144, 32'd12, 33'd0};
        vecs[5] = '{64'd16, 32'd4, 33'd0};
        vecs[6] = '{64'd15, 32'd3, 33'd6};
        vecs[7] = '{64'h1_0000_0000, 32'h1_0000, 33'd0};
        vecs[8] = '{64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 33'd0};
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_root", root, 0);
        chk("reset_rem", rem, 0);
        sys_rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            start(vecs[i].x);
            wait_done(lat);
            chk($sformatf("vec%0d_root", i), root, vecs[i].r);
            chk($sformatf("vec%0d_rem", i), rem, vecs[i].m);
            chk($sformatf("vec%0d_lat", i), lat, exp_lat(vecs[i].x));
            consume;
            chk($sformatf("vec%0d_in_ready_after", i), in_ready, 1);
        end
        start(64'd99);
        wait_done(lat);
        r0 = root;
        m0 = rem;
        for (int i = 0; i < 10; i++) begin
            @(posedge sys_clk); @(negedge sys_clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_root_stable", root, r0);
            chk("bp_rem_stable", rem, m0);
        end
        chk("bp_root", r0, 9);
        consume;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);
        start(64'hDEAD_BEEF_1234_5678);
        repeat (15) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk); @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_root", root, 0);
        chk("midreset_rem", rem, 0);
        start(64'd144);
        wait_done(lat);
        chk("after_reset_root", root, 12);
        chk("after_reset_rem", rem, 0);
        consume;
        start(64'd99);
        in_valid = 1'b1;
        x = 64'd12345;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("busy_in_ready", in_ready, 0);
        in_valid = 1'b0;
        wait_done(lat);
        chk("busy_ignore_root", root, 9);
        chk("busy_ignore_rem", rem, 18);
        consume;
        for (int i = 0; i < 1500; i++) begin
            logic [63:0] v;
            v = {$urandom, $urandom};
            v = v >> $urandom_range(0, 63);
            run_check("rand", v);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
